// File: rtl/iccm_field_writer.sv
// iccm_field_writer
// Read-modify-write engine that replaces one FIELD_W-bit lane of a
// DATA_W-bit bank word. Each request walks IDLE -> RD -> MERGE -> WR, so a
// request takes four cycles and every write-back lands before the next read
// is issued. Back-to-back requests to the same word therefore need no
// forwarding.

module iccm_field_writer #(
    parameter int DATA_W  = 12,
    parameter int FIELD_W = 6,
    parameter int ADDR_W  = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [FIELD_W-1:0]  req_data,

    output logic                bank_rd_en,
    output logic [ADDR_W-2:0]   bank_rd_addr,
    input  logic [DATA_W-1:0]   bank_rd_data,

    output logic                bank_wr_en,
    output logic [ADDR_W-2:0]   bank_wr_addr,
    output logic [DATA_W-1:0]   bank_wr_data,

    output logic                done,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        MERGE = 2'd2,
        WR    = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Request fields captured at acceptance; nothing else on the request
    // bus is looked at until the engine is idle again.
    logic [ADDR_W-2:0]  word_q;
    logic               lane_q;
    logic [FIELD_W-1:0] data_q;

    // Merged word; it stays on bank_wr_data between write-backs.
    logic [DATA_W-1:0]  merged_q;
    logic [DATA_W-1:0]  merged_d;

    logic accept;

    assign accept = (state == IDLE) && req_valid;

    // State register; reset wins over any request presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a fixed four-step walk once a request is taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = req_valid ? RD : IDLE;
            RD:      state_next = MERGE;
            MERGE:   state_next = WR;
            WR:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture the request at acceptance and the merged word in MERGE.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q   <= '0;
            lane_q   <= 1'b0;
            data_q   <= '0;
            merged_q <= '0;
        end else begin
            if (accept) begin
                word_q <= req_addr[ADDR_W-1:1];
                lane_q <= req_addr[0];
                data_q <= req_data;
            end
            if (state == MERGE) begin
                merged_q <= merged_d;
            end
        end
    end

    // Lane replacement: the other lane of the read word passes through.
    always_comb begin
        merged_d = bank_rd_data;
        if (lane_q) begin
            merged_d[DATA_W-1 -: FIELD_W] = data_q;
        end else begin
            merged_d[FIELD_W-1:0] = data_q;
        end
    end

    // Strobes and handshake decoded purely from the state.
    always_comb begin
        req_ready  = 1'b0;
        busy       = 1'b1;
        bank_rd_en = 1'b0;
        bank_wr_en = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            RD: begin
                bank_rd_en = 1'b1;
            end
            MERGE: begin
            end
            WR: begin
                bank_wr_en = 1'b1;
                done       = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bank_rd_addr = word_q;
    assign bank_wr_addr = word_q;
    assign bank_wr_data = merged_q;

endmodule

// File: tb/tb_iccm_field_writer.sv
// tb_iccm_field_writer
// Directed vectors against a small bank model. Each issued request pushes
// its expected bank read and write-back into queues; a negedge monitor pops
// and compares whenever the DUT strobes the bank, and checks the per-cycle
// handshake properties.

module tb_iccm_field_writer;

    localparam int DATA_W  = 12;
    localparam int FIELD_W = 6;
    localparam int ADDR_W  = 4;

    logic               clk;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic [ADDR_W-1:0]  req_addr;
    logic [FIELD_W-1:0] req_data;
    logic               bank_rd_en;
    logic [ADDR_W-2:0]  bank_rd_addr;
    logic [DATA_W-1:0]  bank_rd_data;
    logic               bank_wr_en;
    logic [ADDR_W-2:0]  bank_wr_addr;
    logic [DATA_W-1:0]  bank_wr_data;
    logic               done;
    logic               busy;

    typedef struct {
        logic [ADDR_W-2:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    exp_t rd_q[$];
    exp_t wr_q[$];

    int total;
    int bad;
    int cyc;
    bit mon_en;

    logic [DATA_W-1:0] mem [0:(1<<(ADDR_W-1))-1];
    logic              preload_en;
    logic [ADDR_W-2:0] preload_addr;
    logic [DATA_W-1:0] preload_val;

    iccm_field_writer #(
        .DATA_W (DATA_W),
        .FIELD_W(FIELD_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .bank_rd_en  (bank_rd_en),
        .bank_rd_addr(bank_rd_addr),
        .bank_rd_data(bank_rd_data),
        .bank_wr_en  (bank_wr_en),
        .bank_wr_addr(bank_wr_addr),
        .bank_wr_data(bank_wr_data),
        .done        (done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bank model: read data one cycle after the strobe, junk otherwise so
    // that sampling outside MERGE would corrupt the merge.
    always @(posedge clk) begin
        if (preload_en) mem[preload_addr] <= preload_val;
        if (bank_wr_en) mem[bank_wr_addr] <= bank_wr_data;
        if (bank_rd_en) bank_rd_data <= mem[bank_rd_addr];
        else            bank_rd_data <= 12'($urandom);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: per-cycle properties plus scoreboard pops on bank strobes.
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("rd_wr_exclusive", 32'(bank_rd_en && bank_wr_en), 32'd0);
            checkOutput("done_eq_wr_en", 32'(done), 32'(bank_wr_en));
            checkOutput("ready_eq_not_busy", 32'(req_ready), 32'(!busy));
            if (bank_rd_en) begin
                if (rd_q.size() == 0) begin
                    checkOutput("unexpected_rd", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = rd_q.pop_front();
                    checkOutput("rd_addr", 32'(bank_rd_addr), 32'(e.addr));
                    checkOutput("rd_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (bank_wr_en) begin
                if (wr_q.size() == 0) begin
                    checkOutput("unexpected_wr", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = wr_q.pop_front();
                    checkOutput("wr_addr", 32'(bank_wr_addr), 32'(e.addr));
                    checkOutput("wr_data", 32'(bank_wr_data), 32'(e.data));
                    checkOutput("wr_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic preload(input logic [ADDR_W-2:0] a, input logic [DATA_W-1:0] v);
        preload_en   = 1'b1;
        preload_addr = a;
        preload_val  = v;
        @(posedge clk); #1;
        preload_en   = 1'b0;
    endtask

    task automatic waitAccept(output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checkOutput("accept_timeout", 32'(req_ready), 32'd1);
            acc = -1;
        end else begin
            acc = cyc;
        end
    endtask

    // Issue one request; expected read/write-back are queued at acceptance.
    task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic [FIELD_W-1:0] d,
                                 input logic [DATA_W-1:0] exp_wr, input bit hold,
                                 input bit toggle, output int acc);
        exp_t e;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        waitAccept(acc);
        if (acc >= 0) begin
            e.addr = a[ADDR_W-1:1];
            e.data = '0;
            e.cyc  = acc + 1;
            rd_q.push_back(e);
            e.data = exp_wr;
            e.cyc  = acc + 3;
            wr_q.push_back(e);
        end
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        if (toggle) begin
            repeat (3) begin
                req_addr = 4'($urandom);
                req_data = 6'($urandom);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("idle_timeout", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int a0, a1, a2;
        exp_t e;
        total        = 0;
        bad          = 0;
        cyc          = 0;
        mon_en       = 1'b0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_data     = '0;
        preload_en   = 1'b0;
        preload_addr = '0;
        preload_val  = '0;
        for (int i = 0; i < 8; i++) mem[i] = 12'h000;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rd_en", 32'(bank_rd_en), 32'd0);
        checkOutput("reset_wr_en", 32'(bank_wr_en), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_wr_data", 32'(bank_wr_data), 32'd0);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Lane 0 of word 1: abc -> a95.
        preload(3'd1, 12'habc);
        applyStimulus(4'b0010, 6'h15, 12'ha95, 1'b0, 1'b0, a0);
        waitIdle();

        // Lane 1 of word 1: abc -> ffc.
        preload(3'd1, 12'habc);
        applyStimulus(4'b0011, 6'h3f, 12'hffc, 1'b0, 1'b0, a0);
        waitIdle();

        // Back-to-back to the same word with req_valid held high.
        preload(3'd1, 12'hfff);
        applyStimulus(4'b0010, 6'h00, 12'hfc0, 1'b1, 1'b0, a1);
        applyStimulus(4'b0011, 6'h00, 12'h000, 1'b0, 1'b0, a2);
        checkOutput("b2b_spacing", 32'(a2 - a1), 32'd4);
        waitIdle();

        // Abort in MERGE: a read happens, no write-back, no done.
        preload(3'd2, 12'h5a5);
        req_valid = 1'b1;
        req_addr  = 4'b0100;
        req_data  = 6'h2a;
        waitAccept(a0);
        e.addr = 3'd2;
        e.data = '0;
        e.cyc  = a0 + 1;
        rd_q.push_back(e);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst       = 1'b1;
        req_addr  = 4'b0110;
        req_data  = 6'h01;
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("abort_ready", 32'(req_ready), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_wr_en", 32'(bank_wr_en), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        // Word 2 still 5a5 only if the aborted request never wrote: -> 465.
        applyStimulus(4'b0101, 6'h11, 12'h465, 1'b0, 1'b0, a0);
        waitIdle();

        // Request inputs toggled while busy must not leak in.
        preload(3'd3, 12'h123);
        applyStimulus(4'b0110, 6'h3c, 12'h13c, 1'b0, 1'b1, a0);
        waitIdle();
        preload(3'd7, 12'h0ff);
        applyStimulus(4'b1111, 6'h2a, 12'habf, 1'b0, 1'b1, a0);
        waitIdle();

        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        checkOutput("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        checkOutput("mem_word1", 32'(mem[1]), 32'h000);
        checkOutput("mem_word2", 32'(mem[2]), 32'h465);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/iccm_field_writer.md
ICCM_FIELD_WRITER -- requirements
Module: iccm_field_writer

Interface
REQ-001 The module SHALL have a single clock and a synchronous, active-high reset.
REQ-002 Parameters SHALL be (name, default, meaning):
- DATA_W, 12, bank word width.
- FIELD_W, 6, field width; DATA_W SHALL equal 2*FIELD_W.
- ADDR_W, 4, request address width; bit 0 is the lane, bits [ADDR_W-1:1] are the word index.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- req_valid, in, 1, write request valid.
- req_ready, out, 1, request accepted when high with req_valid.
- req_addr, in, ADDR_W, {word index, lane}.
- req_data, in, FIELD_W, field value to write.
- bank_rd_en, out, 1, bank read strobe.
- bank_rd_addr, out, ADDR_W-1, bank read word index.
- bank_rd_data, in, DATA_W, bank read data, valid exactly one cycle after bank_rd_en.
- bank_wr_en, out, 1, bank write strobe.
- bank_wr_addr, out, ADDR_W-1, bank write word index.
- bank_wr_data, out, DATA_W, merged word.
- done, out, 1, one-cycle pulse on write-back.
- busy, out, 1, high in any non-IDLE state.

Function
REQ-004 The FSM SHALL have the states IDLE, RD, MERGE and WR; all state changes SHALL occur on rising clk.
REQ-005 req_ready SHALL equal (state==IDLE); busy SHALL equal (state!=IDLE).
REQ-006 In IDLE with req_valid=1, the module SHALL register req_addr and req_data and go to RD.
- With req_valid=0 it SHALL stay in IDLE.
REQ-007 In RD, bank_rd_en SHALL be 1 for exactly one cycle, with bank_rd_addr = registered word index; next state SHALL be MERGE.
REQ-008 In MERGE, the module SHALL sample bank_rd_data and form merged = bank_rd_data with bits [FIELD_W*lane +: FIELD_W] replaced by the registered data.
- The other FIELD_W bits SHALL pass through unchanged.
- The merged word SHALL be registered; next state SHALL be WR.
REQ-009 In WR, bank_wr_en and done SHALL be 1 for exactly one cycle, bank_wr_addr SHALL equal the registered word index, and bank_wr_data SHALL equal the registered merged word; next state SHALL be IDLE.
REQ-010 Latency SHALL be fixed: acceptance at cycle N gives rd_en at N+1, data sampled at N+2, wr_en/done at N+3, and req_ready high again at N+4.
- Peak throughput SHALL be one request per 4 cycles.
REQ-011 req_addr and req_data SHALL be ignored outside the acceptance cycle.
- Changes to them while busy SHALL NOT affect the transaction in flight.
REQ-012 bank_rd_en and bank_wr_en SHALL never be high in the same cycle.
REQ-013 bank_rd_data SHALL be ignored in every cycle other than MERGE.
REQ-014 Back-to-back requests to the same word SHALL be correct without forwarding, because each write completes before the next read is issued.
REQ-015 When bank_rd_en, bank_wr_en and done are low, bank_rd_addr, bank_wr_addr and bank_wr_data SHALL hold their last registered values.

Reset
REQ-016 With rst=1 at a rising edge, the next state SHALL be IDLE and all registers SHALL be cleared to 0.
- req_ready=1 and busy=0 SHALL hold in the cycle after reset.
- bank_rd_en=0, bank_wr_en=0 and done=0 SHALL hold in the cycle after reset.
REQ-017 A reset asserted in RD, MERGE or WR SHALL abort the transaction.
- No bank_wr_en or done SHALL be produced for the aborted request.
- A request presented in the same cycle as rst SHALL NOT be accepted.
REQ-018 rst SHALL take priority over every other input.

Verification
REQ-019 Bank word 1 = 12'habc; req_addr=4'b0010, req_data=6'h15 accepted at cycle 0 -> rd_en with rd_addr=1 at cycle 1; wr_en, wr_addr=1, wr_data=12'ha95 and done at cycle 3.
REQ-020 Bank word 1 = 12'habc; req_addr=4'b0011, req_data=6'h3f -> wr_data=12'hffc at cycle 3.
REQ-021 Hold req_valid=1 continuously with two requests to word 1 (lane 0 = 6'h00, then lane 1 = 6'h00) on a bank model initialised to 12'hfff -> writes 12'hfc0 at cycle 3, then 12'h000 at cycle 7; req_ready is high only at cycles 0 and 4.
REQ-022 Assert rst in MERGE -> no wr_en and no done; req_ready=1 in the cycle after reset; the next request then completes normally.
REQ-023 Toggle req_addr and req_data every cycle while busy -> bank accesses use only the values registered at acceptance.
REQ-024 Every run SHALL check these properties each cycle: never (bank_rd_en && bank_wr_en); done == bank_wr_en; req_ready == !busy.
